// File: rtl/pulse_arbiter_if.sv
// Request/grant bundle between requesters, the shared resource and the arbiter.
// master drives raw request levels and done; slave is the arbiter.
interface pulse_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]         sig;
    logic                    done;
    logic                    start;
    logic [$clog2(NREQ)-1:0] sel;
    logic                    active;
    logic [NREQ-1:0]         pending;
    logic                    timeout;

    modport master (
        output sig, done,
        input  start, sel, active, pending, timeout
    );

    modport slave (
        input  sig, done,
        output start, sel, active, pending, timeout
    );
endinterface

// File: rtl/pulse_arbiter.sv
// Edge-detecting round-robin arbiter for one shared resource; start follows a request edge by 2 cycles.
// No backpressure: a grant is released by done or abandoned after TIMEOUT wait cycles.
module pulse_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    pulse_arbiter_if.slave   bus
);
    localparam int SW = $clog2(NREQ);
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] q1_q, q2_q, pending_q, pending_d;
    logic [NREQ-1:0] ev, clr;
    logic [SW-1:0]   sel_q, sel_d, last_q, last_d, win, idx;
    logic            found;
    logic [7:0]      cnt_q, cnt_d;
    logic            start_q, start_d, timeout_q, timeout_d, active_q, active_d;

    assign ev = q1_q & ~q2_q;

    // Round-robin search starting just after the last winner; index arithmetic wraps naturally.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last_q + SW'(k);
            if (!found && pending_q[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        clr       = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    sel_d    = win;
                    last_d   = win;
                    clr[win] = 1'b1;
                    start_d  = 1'b1;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.done) begin
                    state_d = S_IDLE;
                end else if (cnt_q == TLAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        active_d  = (state_d != S_IDLE);
        // A fresh edge in the same cycle as the grant clear keeps the request alive.
        pending_d = (pending_q & ~clr) | ev;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            q1_q      <= '0;
            q2_q      <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            last_q    <= SW'(NREQ - 1);
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            q1_q      <= bus.sig;
            q2_q      <= q1_q;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            start_q   <= start_d;
            timeout_q <= timeout_d;
            active_q  <= active_d;
        end
    end

    assign bus.start   = start_q;
    assign bus.sel     = sel_q;
    assign bus.active  = active_q;
    assign bus.pending = pending_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed bench for pulse_arbiter with TIMEOUT=5: reset, single grant, round-robin, wrap,
// timeout, done/timeout and set/clear collisions, reset mid-grant.
module tb_pulse_arbiter;
    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    pulse_arbiter_if #(.NREQ(4)) bif ();

    pulse_arbiter #(.NREQ(4), .TIMEOUT(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs set after this are sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        nvec++;
        assert (obs === exp_v)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [3:0] rr_pend [4];
        rr_pend[0] = 4'b1110;
        rr_pend[1] = 4'b1100;
        rr_pend[2] = 4'b1000;
        rr_pend[3] = 4'b0000;
        nvec = 0;
        nerr = 0;
        reset    = 1'b0;
        bif.sig  = 4'b0000;
        bif.done = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_active",  8'(bif.active),  8'd0);
        chk("rst_start",   8'(bif.start),   8'd0);
        chk("rst_timeout", 8'(bif.timeout), 8'd0);
        chk("rst_pending", 8'(bif.pending), 8'd0);
        chk("rst_sel",     8'(bif.sel),     8'd0);
        reset = 1'b1;
        tick();

        // Single request on requester 2
        bif.sig = 4'b0100;
        tick();
        chk("single_pend_early", 8'(bif.pending), 8'h0);
        tick();
        chk("single_pend",  8'(bif.pending), 8'h4);
        chk("single_nostart", 8'(bif.start), 8'd0);
        tick();
        chk("single_start", 8'(bif.start),   8'd1);
        chk("single_sel",   8'(bif.sel),     8'd2);
        chk("single_act",   8'(bif.active),  8'd1);
        chk("single_clr",   8'(bif.pending), 8'h0);
        tick();
        chk("single_start_off", 8'(bif.start), 8'd0);
        chk("single_wait_act",  8'(bif.active), 8'd1);
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        chk("single_idle_act", 8'(bif.active),  8'd0);
        chk("single_no_to",    8'(bif.timeout), 8'd0);
        bif.sig = 4'b0000;
        tick();
        tick();

        // Round-robin from a fresh reset: all four rise together
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bif.sig = 4'b1111;
        tick();
        tick();
        chk("rr_pend_all", 8'(bif.pending), 8'hf);
        tick();
        for (int g = 0; g < 4; g++) begin
            chk("rr_start", 8'(bif.start),   8'd1);
            chk("rr_sel",   8'(bif.sel),     8'(g));
            chk("rr_pend",  8'(bif.pending), 8'(rr_pend[g]));
            tick();
            tick();
            tick();
            bif.done = 1'b1;
            tick();
            bif.done = 1'b0;
            chk("rr_idle", 8'(bif.active), 8'd0);
            tick();
        end
        chk("rr_held_nostart", 8'(bif.start),   8'd0);
        chk("rr_held_nopend",  8'(bif.pending), 8'h0);
        bif.sig = 4'b0000;
        tick();
        tick();

        // Wrap: last=3, pending 0110 -> 1 then 2
        bif.sig = 4'b0110;
        tick();
        tick();
        chk("wrap_pend", 8'(bif.pending), 8'h6);
        tick();
        chk("wrap_sel1",   8'(bif.sel),   8'd1);
        chk("wrap_start1", 8'(bif.start), 8'd1);
        tick();
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        tick();
        chk("wrap_sel2",   8'(bif.sel),     8'd2);
        chk("wrap_start2", 8'(bif.start),   8'd1);
        chk("wrap_pend0",  8'(bif.pending), 8'h0);
        tick();
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        bif.sig = 4'b0000;
        tick();
        tick();

        // Timeout: requester 0 granted, requester 3 arrives while waiting
        bif.sig = 4'b0001;
        tick();
        tick();
        tick();
        chk("to_sel0", 8'(bif.sel), 8'd0);
        bif.sig = 4'b1001;
        tick();
        tick();
        chk("to_pend3", 8'(bif.pending), 8'h8);
        tick();
        tick();
        tick();
        chk("to_w5_active", 8'(bif.active),  8'd1);
        chk("to_w5_noto",   8'(bif.timeout), 8'd0);
        tick();
        chk("to_pulse",    8'(bif.timeout), 8'd1);
        chk("to_idle",     8'(bif.active),  8'd0);
        tick();
        chk("to_pulse_off", 8'(bif.timeout), 8'd0);
        chk("to_next_start", 8'(bif.start),  8'd1);
        chk("to_next_sel",   8'(bif.sel),    8'd3);

        // done coincides with the timeout condition in the 5th wait cycle
        tick();
        tick();
        tick();
        tick();
        tick();
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        chk("coll_done_noto", 8'(bif.timeout), 8'd0);
        chk("coll_done_idle", 8'(bif.active),  8'd0);
        bif.sig = 4'b0000;
        tick();
        tick();

        // Set wins over grant clear on requester 1
        bif.sig = 4'b0001;
        tick();
        tick();
        tick();
        bif.sig = 4'b0011;
        tick();
        bif.sig = 4'b0001;
        tick();
        chk("sw_pend1", 8'(bif.pending), 8'h2);
        bif.sig  = 4'b0011;
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        chk("sw_idle", 8'(bif.active), 8'd0);
        tick();
        chk("sw_start1", 8'(bif.start),   8'd1);
        chk("sw_sel1",   8'(bif.sel),     8'd1);
        chk("sw_kept",   8'(bif.pending), 8'h2);
        tick();
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        tick();
        chk("sw_start2", 8'(bif.start),   8'd1);
        chk("sw_sel2",   8'(bif.sel),     8'd1);
        chk("sw_pend0",  8'(bif.pending), 8'h0);
        tick();
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        bif.sig = 4'b0000;
        tick();
        tick();

        // Reset during WAIT with pending 1010
        bif.sig = 4'b0001;
        tick();
        tick();
        tick();
        bif.sig = 4'b1011;
        tick();
        tick();
        chk("rw_pend",   8'(bif.pending), 8'ha);
        chk("rw_active", 8'(bif.active),  8'd1);
        reset   = 1'b0;
        bif.sig = 4'b0010;
        tick();
        chk("rw_active0",  8'(bif.active),  8'd0);
        chk("rw_pending0", 8'(bif.pending), 8'h0);
        chk("rw_start0",   8'(bif.start),   8'd0);
        chk("rw_timeout0", 8'(bif.timeout), 8'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("rw_new_pend", 8'(bif.pending), 8'h2);
        tick();
        chk("rw_new_start", 8'(bif.start), 8'd1);
        chk("rw_new_sel",   8'(bif.sel),   8'd1);
        tick();
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        tick();
        tick();
        chk("rw_once_start", 8'(bif.start),   8'd0);
        chk("rw_once_pend",  8'(bif.pending), 8'h0);
        chk("rw_once_act",   8'(bif.active),  8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
